// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with an optional skid entry, flush and a
// saturating downstream stall counter.
module pipe_stage_reg #(
    parameter int DATA_W  = 128,
    parameter int SKID_EN = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up_valid_i,
    input  logic [DATA_W-1:0] up_data_i,
    output logic              up_ready_o,
    output logic              dn_valid_o,
    output logic [DATA_W-1:0] dn_data_o,
    input  logic              dn_ready_i,
    input  logic              flush_i,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    // Handshake: a beat moves on a side only in a cycle where that side's
    // valid and ready are both high; valid never depends on ready.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              ready_q;
    logic [CNT_W-1:0]  stall_q;
    logic              up_fire, dn_fire;

    assign dn_valid_o  = (state_q != EMPTY);
    assign dn_data_o   = main_q;
    assign occupancy_o = state_q;
    assign stall_cnt_o = stall_q;
    assign up_ready_o  = (SKID_EN != 0) ? ready_q : (!dn_valid_o || dn_ready_i);
    assign up_fire     = up_valid_i && up_ready_o;
    assign dn_fire     = dn_valid_o && dn_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (up_fire) begin
                        state_d = ONE;
                        main_d  = up_data_i;
                    end
                end
                ONE: begin
                    if (dn_fire) begin
                        if (up_fire) main_d = up_data_i;
                        else         state_d = EMPTY;
                    end else if (up_fire && (SKID_EN != 0)) begin
                        state_d = FULL;
                        skid_d  = up_data_i;
                    end
                end
                FULL: begin
                    if (dn_fire) begin
                        main_d = skid_q;
                        if (up_fire) skid_d = up_data_i;
                        else         state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            // Registered ready mirrors "skid entry free" for the next cycle.
            ready_q <= (state_d != FULL);
            if (dn_valid_o && !dn_ready_i && (stall_q != {CNT_W{1'b1}}))
                stall_q <= stall_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table, hand sequences and a
// randomized run against a queue-based model, for skid and non-skid builds.
module tb_pipe_stage_reg;

    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic          a_uv, a_ur, a_dv, a_dr, a_fl;
    logic [DW-1:0] a_ud, a_dd;
    logic [1:0]    a_occ;
    logic [15:0]   a_st;

    logic          b_uv, b_ur, b_dv, b_dr, b_fl;
    logic [DW-1:0] b_ud, b_dd;
    logic [1:0]    b_occ;
    logic [3:0]    b_st;

    pipe_stage_reg #(.DATA_W(DW), .SKID_EN(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .up_valid_i(a_uv), .up_data_i(a_ud), .up_ready_o(a_ur),
        .dn_valid_o(a_dv), .dn_data_o(a_dd), .dn_ready_i(a_dr), .flush_i(a_fl),
        .occupancy_o(a_occ), .stall_cnt_o(a_st)
    );

    pipe_stage_reg #(.DATA_W(DW), .SKID_EN(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .up_valid_i(b_uv), .up_data_i(b_ud), .up_ready_o(b_ur),
        .dn_valid_o(b_dv), .dn_data_o(b_dd), .dn_ready_i(b_dr), .flush_i(b_fl),
        .occupancy_o(b_occ), .stall_cnt_o(b_st)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: the beats held by each stage, oldest first.
    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    logic [DW-1:0] exp_q[$];
    int            st_a, st_b;
    bit            zero_a, zero_b;

    typedef struct {
        logic          uv;
        logic [DW-1:0] d;
        logic          dr;
        logic          fl;
        logic          ev;
        logic [DW-1:0] ed;
        logic          cd;
        logic [1:0]    eo;
        logic          er;
        logic [15:0]   es;
    } vec_t;
    vec_t vt[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_a(input logic uv, input logic [DW-1:0] d, input logic dr, input logic fl);
        a_uv = uv; a_ud = d; a_dr = dr; a_fl = fl;
    endtask

    task automatic drive_b(input logic uv, input logic [DW-1:0] d, input logic dr, input logic fl);
        b_uv = uv; b_ud = d; b_dr = dr; b_fl = fl;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_a(1'b0, '0, 1'b0, 1'b0);
        drive_b(1'b0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        qa.delete(); qb.delete();
        st_a = 0; st_b = 0;
        zero_a = 1'b1; zero_b = 1'b1;
    endtask

    // Inputs already driven; advance one cycle and compare dut_a to the model.
    task automatic step_a(input string tag);
        bit mv, mr, uf, df;
        mv = qa.size() > 0;
        mr = qa.size() < 2;
        uf = a_uv && mr;
        df = mv && a_dr;
        if (mv && !a_dr && st_a < 65535) st_a++;
        if (a_fl) begin
            qa.delete();
            zero_a = 1'b1;
        end else begin
            if (df) void'(qa.pop_front());
            if (uf) begin
                qa.push_back(a_ud);
                zero_a = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk({tag, " a_valid"}, a_dv, qa.size() > 0);
        chk({tag, " a_occ"}, a_occ, qa.size());
        chk({tag, " a_ready"}, a_ur, qa.size() < 2);
        chk({tag, " a_stall"}, a_st, st_a);
        if (qa.size() > 0) chk({tag, " a_data"}, a_dd, qa[0]);
        else if (zero_a) chk({tag, " a_data_zero"}, a_dd, 0);
    endtask

    task automatic step_b(input string tag);
        bit mv, mr, uf, df;
        #1;
        mv = qb.size() > 0;
        mr = !mv || b_dr;
        chk({tag, " b_ready_comb"}, b_ur, mr);
        uf = b_uv && mr;
        df = mv && b_dr;
        if (mv && !b_dr && st_b < 15) st_b++;
        if (b_fl) begin
            qb.delete();
            zero_b = 1'b1;
        end else begin
            if (df) void'(qb.pop_front());
            if (uf) begin
                qb.push_back(b_ud);
                zero_b = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk({tag, " b_valid"}, b_dv, qb.size() > 0);
        chk({tag, " b_occ"}, b_occ, qb.size());
        chk({tag, " b_occ_le1"}, b_occ <= 2'd1, 1);
        chk({tag, " b_stall"}, b_st, st_b);
        if (qb.size() > 0) chk({tag, " b_data"}, b_dd, qb[0]);
        else if (zero_b) chk({tag, " b_data_zero"}, b_dd, 0);
    endtask

    initial begin
        int outs;
        // uv, d, dr, fl | valid, data, check_data, occ, ready, stall
        vt[0]  = '{1'b1, 32'hA5, 1'b1, 1'b0, 1'b1, 32'hA5, 1'b1, 2'd1, 1'b1, 16'd0};
        vt[1]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 2'd0, 1'b1, 16'd0};
        vt[2]  = '{1'b1, 32'h01, 1'b0, 1'b0, 1'b1, 32'h01, 1'b1, 2'd1, 1'b1, 16'd0};
        vt[3]  = '{1'b1, 32'h02, 1'b0, 1'b0, 1'b1, 32'h01, 1'b1, 2'd2, 1'b0, 16'd1};
        vt[4]  = '{1'b1, 32'h03, 1'b0, 1'b0, 1'b1, 32'h01, 1'b1, 2'd2, 1'b0, 16'd2};
        vt[5]  = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 32'h01, 1'b1, 2'd2, 1'b0, 16'd3};
        vt[6]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'h02, 1'b1, 2'd1, 1'b1, 16'd3};
        vt[7]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 2'd0, 1'b1, 16'd3};
        vt[8]  = '{1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 2'd1, 1'b1, 16'd3};
        vt[9]  = '{1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 2'd2, 1'b0, 16'd4};
        vt[10] = '{1'b1, 32'h12, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 2'd0, 1'b1, 16'd5};
        vt[11] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 2'd0, 1'b1, 16'd5};
        vt[12] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 2'd0, 1'b1, 16'd5};
        vt[13] = '{1'b1, 32'h20, 1'b1, 1'b0, 1'b1, 32'h20, 1'b1, 2'd1, 1'b1, 16'd5};
        vt[14] = '{1'b1, 32'h21, 1'b1, 1'b0, 1'b1, 32'h21, 1'b1, 2'd1, 1'b1, 16'd5};
        vt[15] = '{1'b1, 32'h22, 1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 2'd0, 1'b1, 16'd5};

        do_reset();
        chk("reset a_valid", a_dv, 0);
        chk("reset a_data", a_dd, 0);
        chk("reset a_occ", a_occ, 0);
        chk("reset a_ready", a_ur, 1);
        chk("reset a_stall", a_st, 0);
        chk("reset b_valid", b_dv, 0);
        chk("reset b_stall", b_st, 0);

        for (int i = 0; i < 16; i++) begin
            drive_a(vt[i].uv, vt[i].d, vt[i].dr, vt[i].fl);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d valid", i), a_dv, vt[i].ev);
            chk($sformatf("vec%0d occ", i), a_occ, vt[i].eo);
            chk($sformatf("vec%0d ready", i), a_ur, vt[i].er);
            chk($sformatf("vec%0d stall", i), a_st, vt[i].es);
            if (vt[i].cd) chk($sformatf("vec%0d data", i), a_dd, vt[i].ed);
        end

        // Reset wins over flush and a pending beat while full.
        do_reset();
        drive_a(1'b1, 32'h7, 1'b0, 1'b0);
        step_a("rst_fill1");
        drive_a(1'b1, 32'h8, 1'b0, 1'b0);
        step_a("rst_fill2");
        rst = 1'b1;
        drive_a(1'b1, 32'h9, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk("rst_ovr valid", a_dv, 0);
        chk("rst_ovr data", a_dd, 0);
        chk("rst_ovr occ", a_occ, 0);
        chk("rst_ovr ready", a_ur, 1);
        chk("rst_ovr stall", a_st, 0);
        rst = 1'b0;
        qa.delete(); st_a = 0; zero_a = 1'b1;
        drive_a(1'b0, '0, 1'b1, 1'b0);
        step_a("rst_after");

        // Full-rate streaming of beats 1..100.
        do_reset();
        outs = 0;
        for (int i = 1; i <= 100; i++) begin
            drive_a(1'b1, DW'(i), 1'b1, 1'b0);
            exp_q.push_back(DW'(i));
            @(posedge clk);
            #1;
            chk("stream valid", a_dv, 1);
            if (a_dv) begin
                chk("stream data", a_dd, exp_q.pop_front());
                outs++;
            end
        end
        drive_a(1'b0, '0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("stream drained", a_dv, 0);
        chk("stream count", outs, 100);
        chk("stream stall", a_st, 0);
        exp_q.delete();

        // Stall counter saturation on the 4-bit build.
        do_reset();
        drive_b(1'b1, 32'h5, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        drive_b(1'b0, '0, 1'b0, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("sat k=%0d", k), b_st, (k < 15) ? k : 15);
        end

        // Randomized traffic against the model, skid build.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            drive_a($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 40) == 0);
            step_a("rand_a");
        end

        // Randomized traffic, combinational-ready build with toggling dn_ready.
        do_reset();
        for (int n = 0; n < 1000; n++) begin
            drive_b($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) != 0,
                    $urandom_range(0, 40) == 0);
            step_b("rand_b");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter DATA_W SHALL default to 128 and set the payload width in bits; legal range is 1..1024.
REQ-003 Parameter SKID_EN SHALL default to 1; 1 selects a 2-entry registered-ready stage, 0 selects a 1-entry stage with combinational ready.
REQ-004 Parameter CNT_W SHALL default to 16 and set the stall-counter width.
REQ-005 Port clk SHALL be an input, 1 bit wide, and is the rising-edge clock.
REQ-006 Port rst SHALL be an input, 1 bit wide, and is the synchronous active-high reset.
REQ-007 Port up_valid_i SHALL be an input, 1 bit wide, and indicates the upstream stage offers a beat.
REQ-008 Port up_data_i SHALL be an input, DATA_W bits wide, and carries the upstream payload.
REQ-009 Port up_ready_o SHALL be an output, 1 bit wide, and indicates the stage accepts a beat this cycle.
REQ-010 Port dn_valid_o SHALL be an output, 1 bit wide, and indicates the output payload is valid.
REQ-011 Port dn_data_o SHALL be an output, DATA_W bits wide, and carries the output payload.
REQ-012 Port dn_ready_i SHALL be an input, 1 bit wide, and indicates the downstream stage consumes the beat this cycle.
REQ-013 Port flush_i SHALL be an input, 1 bit wide, and requests a synchronous kill of all held and incoming beats.
REQ-014 Port occupancy_o SHALL be an output, 2 bits wide, and reports the number of held beats (0..2).
REQ-015 Port stall_cnt_o SHALL be an output, CNT_W bits wide, and reports the number of downstream back-pressure cycles.

Function
REQ-016 An upstream transfer SHALL occur when up_valid_i && up_ready_o; a downstream transfer SHALL occur when dn_valid_o && dn_ready_i.
REQ-017 With the stage empty, an accepted beat SHALL appear on dn_data_o with dn_valid_o=1 on the following cycle (latency 1).
REQ-018 The storage SHALL be a main register driving dn_* plus, when SKID_EN=1, one skid register.
REQ-019 When SKID_EN=1, up_ready_o SHALL be a registered signal equal to 1 exactly when the skid entry is empty.
REQ-020 When SKID_EN=0, up_ready_o SHALL be computed combinationally as !dn_valid_o || dn_ready_i.
REQ-021 When main is empty, an accepted beat SHALL load into main.
REQ-022 When main is full and a downstream transfer occurs, main SHALL load from skid if skid is valid, else from the accepted beat if one exists, else main SHALL become empty.
REQ-023 When main is full with no downstream transfer and a beat is accepted, the beat SHALL load into skid.
REQ-024 Beats SHALL leave in acceptance order, with no drop or duplication except on flush.
REQ-025 States SHALL be EMPTY (occ 0), ONE (main valid), and FULL (main+skid valid); FULL is reachable only when SKID_EN=1.
REQ-026 The simultaneous upstream transfer and downstream transfer in ONE SHALL keep the state at ONE with new data in main.
REQ-027 Flush SHALL take priority over all transfers: on the next cycle both valids are 0, occupancy_o=0, all data registers are all-zero, the incoming beat is dropped, and up_ready_o=1.
REQ-028 A flush in EMPTY SHALL leave the stage in EMPTY and is otherwise a no-op.
REQ-029 stall_cnt_o SHALL increment by 1 on each cycle with dn_valid_o && !dn_ready_i, saturate at 2^CNT_W-1, and be unaffected by flush.
REQ-030 dn_data_o SHALL be all-zero whenever the stage has been emptied by reset or flush and has not since loaded a beat.

Reset
REQ-031 While rst=1 at a clock edge, the block SHALL set dn_valid_o=0, dn_data_o=0, skid contents=0, occupancy_o=0, stall_cnt_o=0, and up_ready_o=1 (SKID_EN=1).
REQ-032 Reset SHALL override flush and any transfer in progress; the in-flight beats are discarded.

Verification
REQ-033 Test: reset, then up_valid_i=1 with data 0xA5 and dn_ready_i=1 -> the next cycle shows dn_valid_o=1, dn_data_o=0xA5, occupancy_o=1.
REQ-034 Test: SKID_EN=1, beats 1,2 with dn_ready_i=0 -> occupancy_o=2, up_ready_o=0, stall_cnt_o counts +1 per cycle; then dn_ready_i=1 -> outputs 1 then 2 in order.
REQ-035 Test: full streaming with both sides always ready, beats 1..100 -> 100 beats out in order, one per cycle, stall_cnt_o=0.
REQ-036 Test: flush_i=1 in FULL with up_valid_i=1 -> the next cycle shows dn_valid_o=0, dn_data_o=0, occupancy_o=0, and no incoming beat ever emerges.
REQ-037 Test: CNT_W=4 with dn_ready_i held 0 for 20 cycles -> stall_cnt_o stops at 15.
REQ-038 Test: SKID_EN=0 with dn_ready_i toggling -> up_ready_o follows !dn_valid_o||dn_ready_i in the same cycle and occupancy_o never exceeds 1.
